// File: rtl/ppt_pulse_if.sv
// Control/status bundle for ppt_pulse_engine: timebase tick, config bus,
// per-channel start/stop/clear and registered pulse/status outputs.
`timescale 1ns/1ps
interface ppt_pulse_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
);
    logic                      tick_en;
    logic                      cfg_we;
    logic [2:0]                cfg_ch;
    logic [CNT_W-1:0]          cfg_period;
    logic [CNT_W-1:0]          cfg_width;
    logic [BURST_W-1:0]        cfg_burst;
    logic [CNT_W-1:0]          cfg_phase;
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH-1:0]         stop;
    logic [NUM_CH-1:0]         cnt_clr;
    logic [NUM_CH-1:0]         pulse_out;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;
    logic [NUM_CH*CNT_W-1:0]   pulse_count;

    modport master (
        output tick_en, cfg_we, cfg_ch, cfg_period, cfg_width, cfg_burst, cfg_phase,
               start, stop, cnt_clr,
        input  pulse_out, busy, done, pulse_count
    );

    modport slave (
        input  tick_en, cfg_we, cfg_ch, cfg_period, cfg_width, cfg_burst, cfg_phase,
               start, stop, cnt_clr,
        output pulse_out, busy, done, pulse_count
    );
endinterface

// File: rtl/ppt_pulse_engine.sv
// Multi-channel programmable pulse-train generator with per-channel period counters.
// Optional PPT_PHASE_EN adds a per-channel start delay (DELAY state).
`timescale 1ns/1ps
module ppt_pulse_engine #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ppt_pulse_if.slave bus
);
    localparam int unsigned CH_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   width;
        logic [BURST_W-1:0] burst;
`ifdef PPT_PHASE_EN
        logic [CNT_W-1:0]   phase;
`endif
    } cfg_t;

    cfg_t cfg_in;

    // Config bus gathered into one payload
    always_comb begin
        cfg_in        = '0;
        cfg_in.period = bus.cfg_period;
        cfg_in.width  = bus.cfg_width;
        cfg_in.burst  = bus.cfg_burst;
`ifdef PPT_PHASE_EN
        cfg_in.phase  = bus.cfg_phase;
`endif
    end

`ifndef PPT_PHASE_EN
    logic [CNT_W-1:0] unused_phase;
    assign unused_phase = bus.cfg_phase;
`endif

    logic [NUM_CH-1:0]       pulse_vec;
    logic [NUM_CH-1:0]       busy_vec;
    logic [NUM_CH-1:0]       done_vec;
    logic [NUM_CH*CNT_W-1:0] count_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e             state_q, state_d;
        cfg_t               staged_q, staged_d;
        cfg_t               active_q, active_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [CNT_W-1:0]   count_q, count_d;
        logic [BURST_W-1:0] pulses_q, pulses_d, pulses_nxt;
        logic               pulse_q, pulse_d;
        logic               busy_q, busy_d;
        logic               done_q, done_d;
        logic               go_delay;
        logic               wr_hit;
`ifdef PPT_PHASE_EN
        logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
`endif

        assign wr_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

`ifdef PPT_PHASE_EN
        assign go_delay = (staged_q.phase != '0);
`else
        assign go_delay = 1'b0;
`endif

        // Next-state and registered-output logic; stop overrides everything
        always_comb begin
            state_d    = state_q;
            staged_d   = staged_q;
            active_d   = active_q;
            cnt_d      = cnt_q;
            count_d    = count_q;
            pulses_d   = pulses_q;
            pulses_nxt = pulses_q + BURST_W'(1);
            pulse_d    = pulse_q;
            busy_d     = busy_q;
            done_d     = 1'b0;
`ifdef PPT_PHASE_EN
            phase_cnt_d = phase_cnt_q;
`endif
            if (bus.stop[i]) begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start[i] && (staged_q.period != '0)) begin
                            active_d = staged_q;
                            cnt_d    = '0;
                            pulses_d = '0;
                            busy_d   = 1'b1;
`ifdef PPT_PHASE_EN
                            phase_cnt_d = '0;
`endif
                            if (go_delay) begin
                                state_d = ST_DELAY;
                                pulse_d = 1'b0;
                            end else begin
                                state_d = ST_RUN;
                                pulse_d = (staged_q.width != '0);
                            end
                        end
                    end
`ifdef PPT_PHASE_EN
                    ST_DELAY: begin
                        if (bus.tick_en) begin
                            if ((phase_cnt_q + CNT_W'(1)) >= active_q.phase) begin
                                state_d = ST_RUN;
                                cnt_d   = '0;
                                pulse_d = (active_q.width != '0);
                            end else begin
                                phase_cnt_d = phase_cnt_q + CNT_W'(1);
                            end
                        end
                    end
`endif
                    ST_RUN: begin
                        if (bus.tick_en) begin
                            if (cnt_q >= (active_q.period - CNT_W'(1))) begin
                                if (count_q != '1) count_d = count_q + CNT_W'(1);
                                if ((active_q.burst != '0) && (pulses_nxt >= active_q.burst)) begin
                                    state_d = ST_IDLE;
                                    pulse_d = 1'b0;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end else begin
                                    // Period boundary: pending config takes effect here
                                    active_d = staged_q;
                                    cnt_d    = '0;
                                    pulses_d = pulses_nxt;
                                    pulse_d  = (staged_q.width != '0);
                                end
                            end else begin
                                cnt_d   = cnt_q + CNT_W'(1);
                                pulse_d = ((cnt_q + CNT_W'(1)) < active_q.width);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        pulse_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                endcase
            end
            if (bus.cnt_clr[i]) count_d = '0;
            if (wr_hit) staged_d = cfg_in;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                staged_q <= '0;
                active_q <= '0;
                cnt_q    <= '0;
                count_q  <= '0;
                pulses_q <= '0;
                pulse_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
`ifdef PPT_PHASE_EN
                phase_cnt_q <= '0;
`endif
            end else begin
                state_q  <= state_d;
                staged_q <= staged_d;
                active_q <= active_d;
                cnt_q    <= cnt_d;
                count_q  <= count_d;
                pulses_q <= pulses_d;
                pulse_q  <= pulse_d;
                busy_q   <= busy_d;
                done_q   <= done_d;
`ifdef PPT_PHASE_EN
                phase_cnt_q <= phase_cnt_d;
`endif
            end
        end

        assign pulse_vec[i]                = pulse_q;
        assign busy_vec[i]                 = busy_q;
        assign done_vec[i]                 = done_q;
        assign count_vec[i*CNT_W +: CNT_W] = count_q;
    end

    assign bus.pulse_out   = pulse_vec;
    assign bus.busy        = busy_vec;
    assign bus.done        = done_vec;
    assign bus.pulse_count = count_vec;
endmodule

// File: tb/tb_ppt_pulse_engine.sv
// Bench for ppt_pulse_engine: directed scenarios plus random traffic, all checked
// every cycle against a tick-elapsed behavioural model of each channel.
`timescale 1ns/1ps
module tb_ppt_pulse_engine;
    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 16;
    localparam int unsigned BW  = 8;
    localparam int          CMAX = 65535;
`ifdef PPT_PHASE_EN
    localparam int PH_EXP = 5;
    localparam bit PH     = 1'b1;
`else
    localparam int PH_EXP = 0;
    localparam bit PH     = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ppt_pulse_if #(.NUM_CH(NCH), .CNT_W(CW), .BURST_W(BW)) bus ();
    ppt_pulse_engine #(.NUM_CH(NCH), .CNT_W(CW), .BURST_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int tk    = 0;
    int tick_mode = 3;
    bit cmp_en = 1'b0;

    // Behavioural model: staged/active config, ticks elapsed in the current period
    int s_per[NCH], s_wid[NCH], s_bur[NCH], s_pha[NCH];
    int a_per[NCH], a_wid[NCH], a_bur[NCH];
    int m_t[NCH], m_ph[NCH], m_pul[NCH], m_cnt[NCH];
    bit m_run[NCH], m_done[NCH];

    // Directed-test observations
    int high_n[NCH], done_n[NCH], done_cyc[NCH], rise_n[NCH];
    int rise_cyc[NCH][4];
    bit prev_out[NCH];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Shared timebase enable
    initial forever begin
        @(negedge clk);
        tk++;
        case (tick_mode)
            0:       bus.tick_en = 1'b1;
            1:       bus.tick_en = (tk % 4 == 0);
            2:       bus.tick_en = 1'($urandom_range(0, 1));
            default: bus.tick_en = 1'b0;
        endcase
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                s_per[c] = 0; s_wid[c] = 0; s_bur[c] = 0; s_pha[c] = 0;
                a_per[c] = 0; a_wid[c] = 0; a_bur[c] = 0;
                m_t[c] = 0; m_ph[c] = 0; m_pul[c] = 0; m_cnt[c] = 0;
                m_run[c] = 1'b0; m_done[c] = 1'b0;
            end else begin
                m_done[c] = 1'b0;
                if (bus.stop[c]) begin
                    m_run[c] = 1'b0;
                end else if (!m_run[c]) begin
                    if (bus.start[c] && s_per[c] != 0) begin
                        a_per[c] = s_per[c]; a_wid[c] = s_wid[c]; a_bur[c] = s_bur[c];
                        m_t[c] = 0; m_pul[c] = 0; m_run[c] = 1'b1;
                        m_ph[c] = PH ? s_pha[c] : 0;
                    end
                end else if (bus.tick_en) begin
                    if (m_ph[c] > 0) begin
                        m_ph[c]--;
                    end else begin
                        m_t[c]++;
                        if (m_t[c] == a_per[c]) begin
                            if (m_cnt[c] < CMAX) m_cnt[c]++;
                            m_pul[c] = (m_pul[c] + 1) % 256;
                            if (a_bur[c] != 0 && m_pul[c] >= a_bur[c]) begin
                                m_run[c] = 1'b0;
                                m_done[c] = 1'b1;
                            end else begin
                                a_per[c] = s_per[c]; a_wid[c] = s_wid[c]; a_bur[c] = s_bur[c];
                                m_t[c] = 0;
                            end
                        end
                    end
                end
                if (bus.cnt_clr[c]) m_cnt[c] = 0;
                if (bus.cfg_we && bus.cfg_ch == 3'(c)) begin
                    s_per[c] = int'(bus.cfg_period);
                    s_wid[c] = int'(bus.cfg_width);
                    s_bur[c] = int'(bus.cfg_burst);
                    s_pha[c] = int'(bus.cfg_phase);
                end
            end
        end
    end

    // Per-cycle compare against the model, plus observation counters
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (cmp_en) begin
                    n_vec++;
                    if (bus.pulse_out[c] !== (m_run[c] && m_ph[c] == 0 && m_t[c] < a_wid[c]) ||
                        bus.busy[c] !== m_run[c] || bus.done[c] !== m_done[c] ||
                        bus.pulse_count[c*CW +: CW] !== CW'(m_cnt[c])) begin
                        n_err++;
                        $display("FAIL model ch%0d cyc %0d: out/busy/done/count got %b/%b/%b/%0d required %b/%b/%b/%0d",
                                 c, cyc, bus.pulse_out[c], bus.busy[c], bus.done[c],
                                 bus.pulse_count[c*CW +: CW],
                                 (m_run[c] && m_ph[c] == 0 && m_t[c] < a_wid[c]),
                                 m_run[c], m_done[c], m_cnt[c]);
                    end
                end
                if (bus.pulse_out[c]) high_n[c]++;
                if (bus.done[c]) begin
                    done_n[c]++;
                    done_cyc[c] = cyc;
                end
                if (bus.pulse_out[c] && !prev_out[c]) begin
                    if (rise_n[c] < 4) rise_cyc[c][rise_n[c]] = cyc;
                    rise_n[c]++;
                end
                prev_out[c] = bus.pulse_out[c];
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        for (int c = 0; c < NCH; c++) begin
            high_n[c] = 0; done_n[c] = 0; done_cyc[c] = -1000; rise_n[c] = 0;
            for (int k = 0; k < 4; k++) rise_cyc[c][k] = -1000;
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int ch, input int per, input int wid, input int bur, input int pha);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_ch = 3'(ch);
        bus.cfg_period = CW'(per); bus.cfg_width = CW'(wid);
        bus.cfg_burst = BW'(bur); bus.cfg_phase = CW'(pha);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic drive(input logic [NCH-1:0] st, input logic [NCH-1:0] sp, input logic [NCH-1:0] cl);
        @(negedge clk);
        bus.start = st; bus.stop = sp; bus.cnt_clr = cl;
        @(negedge clk);
        bus.start = '0; bus.stop = '0; bus.cnt_clr = '0;
    endtask

    function automatic int cnt_of(input int c);
        return int'(bus.pulse_count[c*CW +: CW]);
    endfunction

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_width = '0;
        bus.cfg_burst = '0; bus.cfg_phase = '0;
        bus.start = '0; bus.stop = '0; bus.cnt_clr = '0; bus.tick_en = 1'b0;
        rst_n = 1'b0;
        mon_clear();
        tick_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", longint'(bus.busy), 0);
        chk("reset_out", longint'(bus.pulse_out), 0);
        chk("reset_count", longint'(bus.pulse_count), 0);

        // Burst: 3 periods of 10 ticks, 2 high
        cfg(0, 10, 2, 3, 0);
        mon_clear();
        drive(2'b01, 2'b00, 2'b00);
        cyc_n(40);
        chk("burst_high_clks", high_n[0], 6);
        chk("burst_done_strobes", done_n[0], 1);
        chk("burst_done_latency", done_cyc[0] - rise_cyc[0][0], 30);
        chk("burst_count", cnt_of(0), 3);
        chk("burst_busy", bus.busy[0], 0);

        // Continuous ch1 on every 4th clk, stop one tick into the sixth period
        tick_mode = 1;
        cfg(1, 4, 1, 0, 0);
        mon_clear();
        drive(2'b10, 2'b00, 2'b00);
        cyc_n(83);
        drive(2'b00, 2'b10, 2'b00);
        chk("cont_count", cnt_of(1), 5);
        chk("cont_out_after_stop", bus.pulse_out[1], 0);
        chk("cont_busy_after_stop", bus.busy[1], 0);
        chk("cont_no_done", done_n[1], 0);

        // Zero period never starts
        tick_mode = 0;
        cfg(0, 0, 2, 0, 0);
        drive(2'b01, 2'b00, 2'b00);
        chk("per0_busy", bus.busy[0], 0);

        // Zero width: periods counted, never high
        cfg(0, 3, 0, 2, 0);
        drive(2'b00, 2'b00, 2'b01);
        mon_clear();
        drive(2'b01, 2'b00, 2'b00);
        cyc_n(10);
        chk("w0_high_clks", high_n[0], 0);
        chk("w0_count", cnt_of(0), 2);
        chk("w0_done", done_n[0], 1);

        // Width beyond period: constant high while busy
        cfg(0, 3, 5, 0, 0);
        mon_clear();
        drive(2'b01, 2'b00, 2'b00);
        cyc_n(20);
        chk("wide_high_clks", high_n[0], 21);
        drive(2'b00, 2'b01, 2'b00);

        // Live reconfig lands on the next period boundary
        cfg(0, 10, 2, 0, 0);
        mon_clear();
        drive(2'b01, 2'b00, 2'b00);
        cfg(0, 6, 2, 0, 0);
        cyc_n(20);
        chk("reconf_first_period", rise_cyc[0][1] - rise_cyc[0][0], 10);
        chk("reconf_second_period", rise_cyc[0][2] - rise_cyc[0][1], 6);
        drive(2'b00, 2'b01, 2'b00);

        // start and stop together
        cfg(1, 4, 1, 0, 0);
        drive(2'b10, 2'b10, 2'b00);
        chk("start_stop_busy", bus.busy[1], 0);

        // Clear coincident with a wrap
        cfg(0, 3, 1, 0, 0);
        drive(2'b00, 2'b00, 2'b01);
        drive(2'b01, 2'b00, 2'b00);
        cyc_n(4);
        drive(2'b00, 2'b00, 2'b01);
        chk("clr_on_wrap", cnt_of(0), 0);
        cyc_n(3);
        chk("count_after_clr", cnt_of(0), 1);
        drive(2'b00, 2'b01, 2'b00);

        // Saturation of the period counter
        cfg(0, 1, 1, 0, 0);
        drive(2'b00, 2'b00, 2'b01);
        drive(2'b01, 2'b00, 2'b00);
        cyc_n(65540);
        chk("sat_value", cnt_of(0), 65535);
        cyc_n(3);
        chk("sat_hold", cnt_of(0), 65535);
        drive(2'b00, 2'b00, 2'b01);
        chk("sat_clear", cnt_of(0), 0);
        drive(2'b00, 2'b01, 2'b00);

        // Phase offset between channels started together
        cfg(0, 10, 2, 0, 0);
        cfg(1, 10, 2, 0, 5);
        mon_clear();
        drive(2'b11, 2'b00, 2'b00);
        cyc_n(12);
        chk("phase_offset", rise_cyc[1][0] - rise_cyc[0][0], PH_EXP);

        // Asynchronous reset while both run
        cyc_n(3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out", longint'(bus.pulse_out), 0);
        chk("async_busy", longint'(bus.busy), 0);
        chk("async_done", longint'(bus.done), 0);
        chk("async_count", longint'(bus.pulse_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc_n(4);
        chk("post_reset_busy", longint'(bus.busy), 0);

        // Random traffic against the model
        tick_mode = 2;
        repeat (2000) begin
            @(negedge clk);
            bus.cfg_we     = ($urandom_range(0, 9) == 0);
            bus.cfg_ch     = 3'($urandom_range(0, 3));
            bus.cfg_period = CW'($urandom_range(1, 12));
            bus.cfg_width  = CW'($urandom_range(0, 14));
            bus.cfg_burst  = BW'($urandom_range(0, 4));
            bus.cfg_phase  = CW'($urandom_range(0, 6));
            for (int c = 0; c < NCH; c++) begin
                bus.start[c]   = ($urandom_range(0, 3) == 0);
                bus.stop[c]    = ($urandom_range(0, 39) == 0);
                bus.cnt_clr[c] = ($urandom_range(0, 59) == 0);
            end
        end
        @(negedge clk);
        bus.cfg_we = 1'b0; bus.start = '0; bus.stop = '0; bus.cnt_clr = '0;
        cyc_n(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ppt_pulse_engine.md
Name: ppt_pulse_engine

Overview:
- Parametrised multi-channel successor to the single pulse generator/pulse counter pair in the PPT controller top.
- Each of NUM_CH channels generates a programmable-period, programmable-width pulse train: continuous or fixed-length burst.
- Each channel counts its completed periods.
- Advances on a shared tick enable (from the clock divider), so the whole block runs on the system clock. Per-channel config is written by the control logic / I2C register front-end.

Parameters:
NUM_CH, 2, number of independent pulse channels (1..8)
CNT_W, 16, width of period/width/phase fields and of each pulse counter
BURST_W, 8, width of burst-length field; 0 selects continuous mode

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_en  input  1  timebase enable; period/width/phase counters advance only when high
cfg_we  input  1  config write strobe
cfg_ch  input  3  target channel for cfg_we; values >= NUM_CH ignored
cfg_period  input  CNT_W  pulse period in ticks
cfg_width  input  CNT_W  high time in ticks
cfg_burst  input  BURST_W  pulses per burst; 0 = continuous
cfg_phase  input  CNT_W  start delay in ticks (used only with PPT_PHASE_EN)
start  input  NUM_CH  per-channel start request, level sampled each clk
stop  input  NUM_CH  per-channel abort
cnt_clr  input  NUM_CH  per-channel pulse counter clear
pulse_out  output  NUM_CH  pulse outputs, registered
busy  output  NUM_CH  channel not IDLE
done  output  NUM_CH  one-clk strobe when a burst completes
pulse_count  output  NUM_CH*CNT_W  completed-period counters; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset: all state IDLE. pulse_out, busy, done = 0. All counters and staged/active config = 0.
- Config: cfg_we latches period/width/burst/phase into the channel's staged registers.
  - Staged → active on accepted start.
  - While busy, staged → active at the next period boundary, i.e. when the tick completes cnt == period-1.
- Per-channel FSM: IDLE, DELAY, RUN.
- IDLE → start accepted when start[i]=1, stop[i]=0 and staged period != 0. Zero period: start ignored, busy stays 0.
  - Accepting start loads active config and sets cnt=0, pulses=0.
  - Next state is DELAY if active phase != 0 (macro enabled), else RUN.
  - busy rises on the clk edge that accepts start.
- DELAY: pulse_out=0. Phase counter increments on tick_en. After phase ticks → RUN with cnt=0.
- RUN:
  - pulse_out = (cnt < width); registered, valid the same edge state/cnt update.
  - width >= period gives constant high; width=0 gives constant low, but periods are still counted.
  - On tick_en, cnt increments. When cnt == period-1: cnt wraps to 0, pulse_count += 1, pulses += 1.
  - If burst != 0 and pulses reaches burst: → IDLE, pulse_out=0, done=1 for exactly one clk.
  - Continuous mode never ends without stop.
- Latency: first high of pulse_out appears on the edge that accepts start (phase 0, width>0). Each tick_en thereafter is one tick.
- stop[i] in any state: → IDLE next edge, pulse_out=0, no done, no count increment for the partial period.
- start while busy: ignored.
- start and stop in the same cycle: stop wins.
- pulse_count saturates at all-ones; it does not wrap.
- cnt_clr and increment in the same cycle: clear wins (result 0).
- pulse_count is not cleared by start.
- Channels are fully independent. No shared state except tick_en and the config bus.

Optional Feature:
- Macro: PPT_PHASE_EN.
- Defined: cfg_phase is staged/applied as above, and the DELAY state is implemented, giving programmable phase offset between channels started in the same cycle.
- Undefined: cfg_phase is ignored, no phase registers exist, DELAY is unreachable, and start always goes directly to RUN.

Test Plan:
- Reset/idle: assert rst_n=0 mid-RUN → pulse_out, busy, done, pulse_count all 0 immediately (async). Release → channels stay IDLE.
- Burst: ch0 period=10, width=2, burst=3, tick_en every clk, start → pulse_out high 2 / low 8 clks, three times. done strobes once on the clk after the 30th tick. pulse_count=3, busy=0.
- Continuous + stop: ch1 period=4, width=1, burst=0, tick_en every 4th clk, run 5 periods, then stop mid-period → pulse_count=5, pulse_out=0 next clk, no done.
- Edge configs:
  - period=0 start → busy stays 0.
  - width=0, period=3, burst=2 → pulse_out never high, pulse_count=2, done asserted.
  - width=5, period=3 → pulse_out constant high while busy.
- Live reconfig/races:
  - Write period=6 while ch0 runs at period=10 → change takes effect only after the current 10-tick period.
  - start+stop in the same clk → remains IDLE.
  - cnt_clr coincident with wrap → count 0.
  - Saturation at 16'hFFFF holds.
- PPT_PHASE_EN: ch0 phase=0, ch1 phase=5, both period=10, width=2, started the same clk → ch1 rising edge exactly 5 ticks after ch0. Without the macro → both rise on the same clk.
